// File: rtl/wbu.sv
// Write-back unit: commits retiring instructions to the integer register file and
// machine CSRs, pulses completion with the next PC, and counts retired instructions.
module wbu (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbu_receive_valid,
    input  logic [31:0] wd,
    input  logic [31:0] csr_wd,
    input  logic [4:0]  rd,
    input  logic [1:0]  csr_rd,
    input  logic        reg_write_en,
    input  logic        csreg_write_en,
    input  logic        ecall,
    input  logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic [31:0] instruction,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rsa,
    output logic [31:0] rsb,
    input  logic [1:0]  csr_ra,
    output logic [31:0] csr_rdata,
    output logic        wbu_ready,
    output logic        wbu_send_valid,
    output logic [31:0] next_pc,
    output logic [31:0] retired_instruction,
    output logic [63:0] retire_count,
    output logic        protocol_error
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [1:0]  CsrMstatus    = 2'd0;
    localparam logic [1:0]  CsrMtvec      = 2'd1;
    localparam logic [1:0]  CsrMepc       = 2'd2;
    localparam logic [1:0]  CsrMcause     = 2'd3;
    localparam logic [31:0] MstatusReset  = 32'h0000_1800;
    localparam logic [31:0] CauseEcallM   = 32'd11;

    state_e      state_q;
    logic        send_valid_q;
    logic        protocol_error_q;
    logic [31:0] next_pc_q;
    logic [31:0] instr_q;
    logic [63:0] retire_count_q;
    logic [63:0] retire_count_d;
    logic [31:0] regs_q [32];
    logic [31:0] csr_q  [4];
    logic        accept;
    logic        csr_write_ok;

    // Accept qualification and next counter value.
    always_comb begin
        accept         = (state_q == StIdle) && wbu_receive_valid;
        retire_count_d = retire_count_q + 64'd1;
        // ecall owns mepc/mcause; a csr write to either is suppressed.
        csr_write_ok   = csreg_write_en && !(ecall && csr_rd[1]);
    end

    // FSM, architectural state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            send_valid_q     <= 1'b0;
            protocol_error_q <= 1'b0;
            next_pc_q        <= '0;
            instr_q          <= '0;
            retire_count_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            csr_q[CsrMstatus] <= MstatusReset;
            csr_q[CsrMtvec]   <= '0;
            csr_q[CsrMepc]    <= '0;
            csr_q[CsrMcause]  <= '0;
        end else begin
            send_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q        <= StBusy;
                        send_valid_q   <= 1'b1;
                        next_pc_q      <= pc_next;
                        instr_q        <= instruction;
                        retire_count_q <= retire_count_d;
                        if (reg_write_en && (rd != 5'd0)) begin
                            regs_q[rd] <= wd;
                        end
                        if (csr_write_ok) begin
                            csr_q[csr_rd] <= csr_wd;
                        end
                        if (ecall) begin
                            csr_q[CsrMepc]   <= pc;
                            csr_q[CsrMcause] <= CauseEcallM;
                        end
                    end
                end
                StBusy: begin
                    state_q <= StIdle;
                    if (wbu_receive_valid) begin
                        protocol_error_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Combinational read ports, no bypass from the accepting payload.
    always_comb begin
        rsa       = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
        rsb       = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
        csr_rdata = csr_q[csr_ra];
    end

    assign wbu_ready           = (state_q == StIdle);
    assign wbu_send_valid      = send_valid_q;
    assign next_pc             = next_pc_q;
    assign retired_instruction = instr_q;
    assign retire_count        = retire_count_q;
    assign protocol_error      = protocol_error_q;

endmodule

// File: tb/tb_wbu.sv
// Scoreboard bench for wbu: issued instructions push expected completions, a monitor
// pops and compares on each wbu_send_valid; state/read-port checks are directed.
module tb_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbu_receive_valid;
    logic [31:0] wd, csr_wd, pc, pc_next, instruction;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  csr_rd, csr_ra;
    logic        reg_write_en, csreg_write_en, ecall;
    logic [31:0] rsa, rsb, csr_rdata, next_pc, retired_instruction;
    logic        wbu_ready, wbu_send_valid, protocol_error;
    logic [63:0] retire_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] instr;
        logic [63:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    wbu dut (
        .clk                 (clk),
        .rst                 (rst),
        .wbu_receive_valid   (wbu_receive_valid),
        .wd                  (wd),
        .csr_wd              (csr_wd),
        .rd                  (rd),
        .csr_rd              (csr_rd),
        .reg_write_en        (reg_write_en),
        .csreg_write_en      (csreg_write_en),
        .ecall               (ecall),
        .pc                  (pc),
        .pc_next             (pc_next),
        .instruction         (instruction),
        .rs1                 (rs1),
        .rs2                 (rs2),
        .rsa                 (rsa),
        .rsb                 (rsb),
        .csr_ra              (csr_ra),
        .csr_rdata           (csr_rdata),
        .wbu_ready           (wbu_ready),
        .wbu_send_valid      (wbu_send_valid),
        .next_pc             (next_pc),
        .retired_instruction (retired_instruction),
        .retire_count        (retire_count),
        .protocol_error      (protocol_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (wbu_send_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got next_pc %h expected none", next_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("next_pc", {32'd0, next_pc}, {32'd0, e.npc});
                chk("retired_instruction", {32'd0, retired_instruction}, {32'd0, e.instr});
                chk("retire_count", retire_count, e.cnt);
            end
        end
    end

    task automatic idle_inputs();
        wbu_receive_valid = 1'b0;
        wd = '0; csr_wd = '0; rd = '0; csr_rd = '0;
        reg_write_en = 1'b0; csreg_write_en = 1'b0; ecall = 1'b0;
        pc = '0; pc_next = '0; instruction = '0;
    endtask

    // Drive one accept pulse at a negedge; returns at the negedge of cycle N+1.
    task automatic issue(input logic [4:0] r, input logic [31:0] w, input logic we,
                         input logic [1:0] cr, input logic [31:0] cw, input logic cwe,
                         input logic ec, input logic [31:0] p, input logic [31:0] pn,
                         input logic [31:0] ins, input logic [63:0] exp_cnt);
        sb_q.push_back('{npc: pn, instr: ins, cnt: exp_cnt});
        rd = r; wd = w; reg_write_en = we;
        csr_rd = cr; csr_wd = cw; csreg_write_en = cwe;
        ecall = ec; pc = p; pc_next = pn; instruction = ins;
        wbu_receive_valid = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic rd_csr(input logic [1:0] idx, input string name, input logic [31:0] exp);
        csr_ra = idx;
        #1;
        chk(name, {32'd0, csr_rdata}, {32'd0, exp});
    endtask

    task automatic rd_x(input logic [4:0] idx, input string name, input logic [31:0] exp);
        rs1 = idx;
        rs2 = idx;
        #1;
        chk({name, "_rsa"}, {32'd0, rsa}, {32'd0, exp});
        chk({name, "_rsb"}, {32'd0, rsb}, {32'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rs1 = '0; rs2 = '0; csr_ra = '0;
        rst = 1'b1;
        // A valid during reset must be ignored.
        wbu_receive_valid = 1'b1; rd = 5'd2; wd = 32'hFFFF; reg_write_en = 1'b1;
        repeat (2) @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {63'd0, wbu_ready}, 64'd1);
        chk("rst_send_valid", {63'd0, wbu_send_valid}, 64'd0);
        chk("rst_perr", {63'd0, protocol_error}, 64'd0);
        chk("rst_next_pc", {32'd0, next_pc}, 64'd0);
        chk("rst_instr", {32'd0, retired_instruction}, 64'd0);
        chk("rst_count", retire_count, 64'd0);
        rd_x(5'd5, "rst_x5", 32'd0);
        rd_x(5'd2, "rst_x2", 32'd0);
        rd_csr(2'd0, "rst_mstatus", 32'h0000_1800);
        rd_csr(2'd1, "rst_mtvec", 32'd0);
        rd_csr(2'd2, "rst_mepc", 32'd0);
        rd_csr(2'd3, "rst_mcause", 32'd0);
        @(negedge clk);

        // Integer write, latency and single-cycle pulse
        issue(5'd3, 32'hDEADBEEF, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0,
              32'h8000_0000, 32'h8000_0004, 32'h0000_0013, 64'd1);
        chk("busy_ready", {63'd0, wbu_ready}, 64'd0);
        rd_x(5'd3, "x3", 32'hDEADBEEF);
        @(negedge clk);
        chk("n2_send_valid", {63'd0, wbu_send_valid}, 64'd0);
        chk("n2_ready", {63'd0, wbu_ready}, 64'd1);
        chk("n2_next_pc_stable", {32'd0, next_pc}, {32'd0, 32'h8000_0004});

        // x0 discard
        issue(5'd0, 32'h1234, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0,
              32'h8000_0004, 32'h8000_0008, 32'h0010_0013, 64'd2);
        rd_x(5'd0, "x0", 32'd0);
        @(negedge clk);

        // ecall beats csr write to mepc; reg write still honoured
        issue(5'd5, 32'h77, 1'b1, 2'd2, 32'h5555, 1'b1, 1'b1,
              32'h8000_0100, 32'h0000_0200, 32'h0000_0073, 64'd3);
        rd_csr(2'd2, "ecall_mepc", 32'h8000_0100);
        rd_csr(2'd3, "ecall_mcause", 32'd11);
        rd_x(5'd5, "ecall_x5", 32'h77);
        @(negedge clk);

        // ecall with non-conflicting mtvec write
        issue(5'd0, 32'd0, 1'b0, 2'd1, 32'h5555, 1'b1, 1'b1,
              32'h8000_0200, 32'h0000_0200, 32'h0000_0073, 64'd4);
        rd_csr(2'd1, "ecall_mtvec", 32'h5555);
        rd_csr(2'd2, "ecall2_mepc", 32'h8000_0200);
        @(negedge clk);

        // Plain csr write to mcause, no ecall
        issue(5'd0, 32'd0, 1'b0, 2'd3, 32'hABC, 1'b1, 1'b0,
              32'h0000_0200, 32'h0000_0204, 32'h3420_1073, 64'd5);
        rd_csr(2'd3, "csr_mcause", 32'hABC);
        rd_csr(2'd0, "csr_mstatus_kept", 32'h0000_1800);
        @(negedge clk);

        // Back-to-back pulses: second dropped, protocol_error sticky
        sb_q.push_back('{npc: 32'h0000_0208, instr: 32'h0660_0313, cnt: 64'd6});
        rd = 5'd6; wd = 32'h66; reg_write_en = 1'b1;
        pc_next = 32'h0000_0208; instruction = 32'h0660_0313;
        wbu_receive_valid = 1'b1;
        @(negedge clk);
        rd = 5'd4; wd = 32'd9; pc_next = 32'h0000_0ABC; instruction = 32'h0090_0213;
        @(negedge clk);
        idle_inputs();
        rd_x(5'd4, "dropped_x4", 32'd0);
        rd_x(5'd6, "x6", 32'h66);
        chk("dropped_count", retire_count, 64'd6);
        chk("perr_set", {63'd0, protocol_error}, 64'd1);
        chk("dropped_next_pc", {32'd0, next_pc}, {32'd0, 32'h0000_0208});
        repeat (3) @(negedge clk);
        chk("perr_held", {63'd0, protocol_error}, 64'd1);
        issue(5'd7, 32'h70, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0,
              32'h0000_0208, 32'h0000_020C, 32'h0700_0393, 64'd7);
        chk("perr_after_accept", {63'd0, protocol_error}, 64'd1);
        @(negedge clk);

        // Reset asserted in BUSY wins; valid in reset cycle ignored
        issue(5'd8, 32'h88, 1'b1, 2'd1, 32'h99, 1'b1, 1'b0,
              32'h0000_020C, 32'h0000_0210, 32'h0880_0413, 64'd8);
        rst = 1'b1;
        wbu_receive_valid = 1'b1; rd = 5'd9; wd = 32'h99; reg_write_en = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        chk("midrst_ready", {63'd0, wbu_ready}, 64'd1);
        chk("midrst_send_valid", {63'd0, wbu_send_valid}, 64'd0);
        chk("midrst_count", retire_count, 64'd0);
        chk("midrst_perr", {63'd0, protocol_error}, 64'd0);
        chk("midrst_next_pc", {32'd0, next_pc}, 64'd0);
        rd_x(5'd3, "midrst_x3", 32'd0);
        rd_x(5'd8, "midrst_x8", 32'd0);
        rd_x(5'd9, "midrst_x9", 32'd0);
        rd_csr(2'd1, "midrst_mtvec", 32'd0);
        rd_csr(2'd0, "midrst_mstatus", 32'h0000_1800);
        @(negedge clk);

        // Counter wrap from all-ones
        force dut.retire_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_count_q;
        #1;
        chk("preset_count", retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        issue(5'd1, 32'h1, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0,
              32'h0000_0000, 32'h0000_0004, 32'h0010_0093, 64'd0);
        @(negedge clk);
        chk("wrap_count_held", retire_count, 64'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
